alu_unit: RTL and testbench



---
 rtl/alu_unit.sv | 125 ++++++++++++
 tb/tb_alu_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: registered WIDTH-bit ALU with carry, overflow, negative and zero flags.
// One-cycle latency, a new operation every clock, and no combinational path to the outputs.
// Optional feature macro: ALU_ROTATE_EN enables ROL/ROR (opcodes 1100/1101).
// Without the macro those opcodes produce a zero result with only `zero` set.
module alu_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    typedef enum logic [3:0] {
        OP_LSL   = 4'b0000,
        OP_LSR   = 4'b0001,
        OP_ASR   = 4'b0010,
        OP_NOT   = 4'b0011,
        OP_AND   = 4'b0100,
        OP_OR    = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_ADD   = 4'b0111,
        OP_SUB   = 4'b1000,
        OP_NAND  = 4'b1001,
        OP_NOR   = 4'b1010,
        OP_XNOR  = 4'b1011,
        OP_ROL   = 4'b1100,
        OP_ROR   = 4'b1101,
        OP_PASSA = 4'b1110,
        OP_PASSB = 4'b1111
    } op_e;

    // WIDTH always fits in WIDTH bits because WIDTH >= 2
    localparam logic [WIDTH-1:0] W_AMT = WIDTH'(WIDTH);

    op_e            op;
    logic           big_shift;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH-1:0] y_next;
    logic           c_next;
    logic           v_next;

`ifdef ALU_ROTATE_EN
    logic [WIDTH-1:0]   rot_amt;
    logic [2*WIDTH-1:0] rol_tmp;
    logic [2*WIDTH-1:0] ror_tmp;

    // Rotate by shifting a doubled copy of `a` and keeping the appropriate half
    always_comb begin
        rot_amt = b % W_AMT;
        rol_tmp = {a, a} << rot_amt;
        ror_tmp = {a, a} >> rot_amt;
    end
`endif

    assign op        = op_e'(opcode);
    assign big_shift = (b >= W_AMT);
    assign sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Next-state result and arithmetic flags for the selected operation
    always_comb begin
        y_next = '0;
        c_next = 1'b0;
        v_next = 1'b0;
        unique case (op)
            OP_LSL:   y_next = big_shift ? '0 : (a << b);
            OP_LSR:   y_next = big_shift ? '0 : (a >> b);
            OP_ASR:   y_next = big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            OP_NOT:   y_next = ~a;
            OP_AND:   y_next = a & b;
            OP_OR:    y_next = a | b;
            OP_XOR:   y_next = a ^ b;
            OP_ADD: begin
                y_next = sum[WIDTH-1:0];
                c_next = sum[WIDTH];
                v_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y_next = diff[WIDTH-1:0];
                c_next = diff[WIDTH];
                v_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NAND:  y_next = ~(a & b);
            OP_NOR:   y_next = ~(a | b);
            OP_XNOR:  y_next = ~(a ^ b);
`ifdef ALU_ROTATE_EN
            OP_ROL:   y_next = rol_tmp[2*WIDTH-1:WIDTH];
            OP_ROR:   y_next = ror_tmp[WIDTH-1:0];
`else
            OP_ROL:   y_next = '0;
            OP_ROR:   y_next = '0;
`endif
            OP_PASSA: y_next = a;
            OP_PASSB: y_next = b;
            default:  y_next = '0;
        endcase
    end

    // Output register; reset clears every output including `zero`
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else begin
            y        <= y_next;
            cout     <= c_next;
            overflow <= v_next;
            negative <= y_next[WIDTH-1];
            zero     <= (y_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit at WIDTH=4.
// Observed word is {y, cout, overflow, negative, zero}; expectations are hand-computed.
module tb_alu_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] y;
    logic       cout;
    logic       overflow;
    logic       negative;
    logic       zero;

    int unsigned n_checks;
    int unsigned n_pass;

    alu_unit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .y        (y),
        .cout     (cout),
        .overflow (overflow),
        .negative (negative),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got y/c/v/n/z=%b_%b required %b_%b",
                      tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
    endtask

    function automatic logic [7:0] outs();
        return {y, cout, overflow, negative, zero};
    endfunction

    // exp = {y, cout, overflow, negative, zero}
    task automatic apply(input string tag, input logic [3:0] op, input logic [3:0] va,
                         input logic [3:0] vb, input logic vc, input logic [7:0] exp);
        @(negedge clk);
        opcode = op;
        a      = va;
        b      = vb;
        cin    = vc;
        @(posedge clk);
        #1;
        check_eq(tag, outs(), exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        opcode   = 4'b0000;
        a        = 4'b0000;
        b        = 4'b0000;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", outs(), 8'b0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Shifts
        apply("lsl_1",        4'b0000, 4'b0001, 4'b0001, 1'b0, 8'b0010_0000);
        apply("lsr_1",        4'b0001, 4'b0001, 4'b0001, 1'b0, 8'b0000_0001);
        apply("asr_neg",      4'b0010, 4'b1001, 4'b0001, 1'b0, 8'b1100_0010);
        apply("asr_pos",      4'b0010, 4'b0001, 4'b0001, 1'b0, 8'b0000_0001);
        apply("lsl_3",        4'b0000, 4'b0011, 4'b0011, 1'b0, 8'b1000_0010);
        // Logic
        apply("not",          4'b0011, 4'b1000, 4'b0000, 1'b0, 8'b0111_0000);
        apply("and",          4'b0100, 4'b1111, 4'b0111, 1'b0, 8'b0111_0000);
        apply("or",           4'b0101, 4'b1010, 4'b0101, 1'b0, 8'b1111_0010);
        apply("xor",          4'b0110, 4'b1100, 4'b1010, 1'b0, 8'b0110_0000);
        apply("nand",         4'b1001, 4'b1100, 4'b1010, 1'b0, 8'b0111_0000);
        apply("nor",          4'b1010, 4'b1100, 4'b1010, 1'b0, 8'b0001_0000);
        apply("xnor",         4'b1011, 4'b1100, 4'b1010, 1'b0, 8'b1001_0010);
        apply("and_cin_ign",  4'b0100, 4'b1111, 4'b1111, 1'b1, 8'b1111_0010);
        apply("passa",        4'b1110, 4'b1011, 4'b0100, 1'b0, 8'b1011_0010);
        apply("passb",        4'b1111, 4'b1011, 4'b0100, 1'b0, 8'b0100_0000);
        // Arithmetic
        apply("add_ovf",      4'b0111, 4'b0111, 4'b0001, 1'b0, 8'b1000_0110);
        apply("add_carry",    4'b0111, 4'b1111, 4'b0000, 1'b1, 8'b0000_1001);
        apply("add_cin",      4'b0111, 4'b0010, 4'b0011, 1'b1, 8'b0110_0000);
        apply("add_neg_ovf",  4'b0111, 4'b1000, 4'b1000, 1'b0, 8'b0000_1101);
        apply("sub_borrow",   4'b1000, 4'b0011, 4'b0101, 1'b0, 8'b1110_0010);
        apply("sub_noborrow", 4'b1000, 4'b0101, 4'b0011, 1'b1, 8'b0010_1000);
        apply("sub_ovf",      4'b1000, 4'b0111, 4'b1000, 1'b0, 8'b1111_0110);
        // Shift-amount boundaries
        apply("lsl_big",      4'b0000, 4'b1111, 4'b0100, 1'b0, 8'b0000_0001);
        apply("lsr_big",      4'b0001, 4'b1000, 4'b0101, 1'b0, 8'b0000_0001);
        apply("asr_big_neg",  4'b0010, 4'b1000, 4'b1111, 1'b0, 8'b1111_0010);
        apply("asr_big_pos",  4'b0010, 4'b0110, 4'b0100, 1'b0, 8'b0000_0001);
        // Rotates
`ifdef ALU_ROTATE_EN
        apply("rol_mod",      4'b1100, 4'b1001, 4'b0101, 1'b0, 8'b0011_0000);
        apply("ror_1",        4'b1101, 4'b1001, 4'b0001, 1'b0, 8'b1100_0010);
        apply("rol_zero_amt", 4'b1100, 4'b0110, 4'b0100, 1'b0, 8'b0110_0000);
`else
        apply("rol_off",      4'b1100, 4'b1001, 4'b0101, 1'b1, 8'b0000_0001);
        apply("ror_off",      4'b1101, 4'b1001, 4'b0001, 1'b0, 8'b0000_0001);
        apply("rol_off_b4",   4'b1100, 4'b0110, 4'b0100, 1'b0, 8'b0000_0001);
`endif

        // Mid-cycle reset clears outputs immediately and holds until the edge after release
        apply("pre_reset_add", 4'b0111, 4'b0111, 4'b0001, 1'b0, 8'b1000_0110);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("reset_async", outs(), 8'b0000_0000);
        @(posedge clk);
        #1;
        check_eq("reset_hold", outs(), 8'b0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_release", outs(), 8'b0000_0000);
        @(posedge clk);
        #1;
        check_eq("post_reset_add", outs(), 8'b1000_0110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
